// File: rtl/bcd_seg_counter_pkg.sv
// Shared segment patterns and helpers for the BCD 7-seg counter.
// Bit order {dp,g,f,e,d,c,b,a}, active-high.
`timescale 1ns/1ps
package bcd_seg_counter_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // The decimal point is never driven by this block.
  localparam logic [7:0] SEG_DP_MASK = 8'h80;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] d
  );
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_seg_counter_seg7_decode.sv
// One BCD digit to a 7-segment pattern, combinational.
// Codes above 9 cannot reach this decoder and show blank.
`timescale 1ns/1ps
module seg7_decode
  import bcd_seg_counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  logic [7:0] pat;

  // Table lookup of the segment pattern.
  always_comb begin
    pat = SEG_BLANK;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
  end

  assign seg = pat & ~SEG_DP_MASK;

endmodule

// File: rtl/bcd_seg_counter.sv
// N-digit BCD up/down counter with prescaler and 7-seg drive.
// Define BLANK_LEADING_ZERO_EN to blank leading zero digits.
`timescale 1ns/1ps
module bcd_seg_counter
  import bcd_seg_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [8*DIGITS-1:0]   SEG,
  output logic                  TICK,
  output logic                  OVF
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(PRESCALE - 1);

`ifdef BLANK_LEADING_ZERO_EN
  localparam bit BLANK_LZ = 1'b1;
`else
  localparam bit BLANK_LZ = 1'b0;
`endif

  function automatic logic [8*DIGITS-1:0] rst_seg();
    logic [8*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++)
      r[8*i+:8] = (BLANK_LZ && i > 0)
                  ? SEG_BLANK : SEG_0;
    return r;
  endfunction

  localparam logic [8*DIGITS-1:0] SEG_RST = rst_seg();

  logic [PW-1:0]       pcnt;
  logic                tick_i;
  logic [4*DIGITS-1:0] nxt;
  logic [4*DIGITS-1:0] ld;
  logic                wrap;
  logic                cy;
  logic [3:0]          dg;
  logic [DIGITS-1:0]   blank;
  logic [8*DIGITS-1:0] raw;
  logic [8*DIGITS-1:0] dec;

  assign tick_i = EN && (pcnt == PMAX);

  // Ripple +1/-1 through the digits; leftover carry means wrap.
  always_comb begin
    nxt = BCD;
    cy  = 1'b1;
    dg  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dg = BCD[4*i+:4];
      if (cy) begin
        if (UP) begin
          if (dg == 4'd9) begin
            nxt[4*i+:4] = 4'd0;
          end else begin
            nxt[4*i+:4] = dg + 4'd1;
            cy = 1'b0;
          end
        end else begin
          if (dg == 4'd0) begin
            nxt[4*i+:4] = 4'd9;
          end else begin
            nxt[4*i+:4] = dg - 4'd1;
            cy = 1'b0;
          end
        end
      end
    end
    wrap = cy;
  end

  // Clamp out-of-range load digits to 9.
  always_comb begin
    ld = '0;
    for (int i = 0; i < DIGITS; i++)
      ld[4*i+:4] = bcd_clamp(LOAD_VAL[4*i+:4]);
  end

`ifdef BLANK_LEADING_ZERO_EN
  logic nz;

  // Blank zero digits above the top non-zero digit.
  always_comb begin
    blank = '0;
    nz    = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz       = nz | (BCD[4*i+:4] != 4'd0);
      blank[i] = ~nz;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (BCD[4*g+:4]),
      .seg (raw[8*g+:8])
    );
  end

  // Apply per-digit blanking to decoded patterns.
  always_comb begin
    dec = raw;
    for (int i = 0; i < DIGITS; i++)
      if (blank[i]) dec[8*i+:8] = SEG_BLANK;
  end

  // Prescaler, count register and tick/wrap pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt <= '0;
      BCD  <= '0;
      TICK <= 1'b0;
      OVF  <= 1'b0;
    end else if (LOAD) begin
      pcnt <= '0;
      BCD  <= ld;
      TICK <= 1'b0;
      OVF  <= 1'b0;
    end else begin
      TICK <= tick_i;
      OVF  <= tick_i & wrap;
      if (EN)
        pcnt <= tick_i ? '0 : pcnt + 1'b1;
      if (tick_i)
        BCD <= nxt;
    end
  end

  // Registered segment drive, one cycle behind BCD.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) SEG <= SEG_RST;
    else     SEG <= dec;
  end

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Bench for bcd_seg_counter: decimal model plus directed checks.
// Honours BLANK_LEADING_ZERO_EN when defined.
`timescale 1ns/1ps
module tb_bcd_seg_counter;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 2;

`ifdef BLANK_LEADING_ZERO_EN
  localparam bit BLZ = 1'b1;
`else
  localparam bit BLZ = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        UP = 1'b1;
  logic        LOAD = 1'b0;
  logic [15:0] LOAD_VAL = '0;
  logic [15:0] BCD;
  logic [31:0] SEG;
  logic        TICK;
  logic        OVF;

  bcd_seg_counter #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .UP       (UP),
    .LOAD     (LOAD),
    .LOAD_VAL (LOAD_VAL),
    .BCD      (BCD),
    .SEG      (SEG),
    .TICK     (TICK),
    .OVF      (OVF)
  );

  always #1 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n_tick = 0;
  int n_ovf  = 0;

  logic [7:0] pat [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F,
                           8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F};

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] seg_of(input int v);
    logic [31:0] r;
    int p;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (BLZ && i > 0 && v < p) r[8*i+:8] = 8'h00;
      else r[8*i+:8] = pat[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int val_of(input logic [15:0] lv);
    int s;
    int p;
    int d;
    s = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i+:4]);
      if (d > 9) d = 9;
      s = s + d * p;
      p = p * 10;
    end
    return s;
  endfunction

  // Decimal model of the counter.
  int m_cnt  = 0;
  int m_p    = 0;
  int m_segv = 0;
  bit m_tick = 0;
  bit m_ovf  = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_cnt = 0; m_p = 0; m_segv = 0;
      m_tick = 0; m_ovf = 0;
    end else begin
      m_segv = m_cnt;
      m_tick = 0;
      m_ovf  = 0;
      if (LOAD) begin
        m_cnt = val_of(LOAD_VAL);
        m_p   = 0;
      end else if (EN) begin
        if (m_p == PRESCALE - 1) begin
          m_p    = 0;
          m_tick = 1;
          if (UP) begin
            m_ovf = (m_cnt == 9999);
            m_cnt = (m_cnt + 1) % 10000;
          end else begin
            m_ovf = (m_cnt == 0);
            m_cnt = (m_cnt == 0) ? 9999 : m_cnt - 1;
          end
        end else begin
          m_p++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("bcd", 32'(BCD), 32'(bcd_of(m_cnt)));
    chk("seg", SEG, seg_of(m_segv));
    chk("tick", 32'(TICK), 32'(m_tick));
    chk("ovf", 32'(OVF), 32'(m_ovf));
    if (TICK) n_tick++;
    if (OVF) n_ovf++;
  end

  localparam logic [31:0] S_RST =
    BLZ ? 32'h0000003F : 32'h3F3F3F3F;
  localparam logic [31:0] S_10 =
    BLZ ? 32'h0000063F : 32'h3F3F063F;

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_bcd", 32'(BCD), 32'h0);
    chk("rst_seg", SEG, S_RST);
    chk("rst_tick", 32'(TICK), 32'h0);
    chk("rst_ovf", 32'(OVF), 32'h0);
    #0.3 RST = 1'b0;

    @(negedge CLK);
    n_tick = 0;
    EN = 1'b1; UP = 1'b1;
    repeat (20) @(negedge CLK);
    EN = 1'b0;
    chk("up20_bcd", 32'(BCD), 32'h0010);
    @(negedge CLK);
    chk("up20_seg", SEG, S_10);
    chk("up20_ticks", 32'(n_tick), 32'd10);

    LOAD = 1'b1; LOAD_VAL = 16'h9999;
    @(negedge CLK);
    LOAD = 1'b0; n_ovf = 0; n_tick = 0;
    EN = 1'b1; UP = 1'b1;
    repeat (2) @(negedge CLK);
    EN = 1'b0;
    chk("wrap_up_bcd", 32'(BCD), 32'h0000);
    @(negedge CLK);
    chk("wrap_up_ovf", 32'(n_ovf), 32'd1);
    chk("wrap_up_tick", 32'(n_tick), 32'd1);

    LOAD = 1'b1; LOAD_VAL = 16'h0000; UP = 1'b0;
    @(negedge CLK);
    LOAD = 1'b0; n_ovf = 0;
    EN = 1'b1;
    repeat (2) @(negedge CLK);
    EN = 1'b0;
    chk("wrap_dn_bcd", 32'(BCD), 32'h9999);
    @(negedge CLK);
    chk("wrap_dn_ovf", 32'(n_ovf), 32'd1);
    chk("wrap_dn_seg", SEG, 32'h6F6F6F6F);

    LOAD = 1'b1; LOAD_VAL = 16'h0000;
    @(negedge CLK);
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    @(negedge CLK);
    LOAD = 1'b1; LOAD_VAL = 16'h12AF;
    n_tick = 0; n_ovf = 0;
    @(negedge CLK);
    LOAD = 1'b0;
    chk("ld_clamp_bcd", 32'(BCD), 32'h1299);
    @(negedge CLK);
    chk("ld_no_tick", 32'(n_tick), 32'd0);
    chk("ld_no_ovf", 32'(n_ovf), 32'd0);
    chk("ld_pre_restart", 32'(BCD), 32'h1299);
    @(negedge CLK);
    chk("ld_resume_bcd", 32'(BCD), 32'h1300);
    EN = 1'b0;

    LOAD = 1'b1; LOAD_VAL = 16'h0123;
    @(negedge CLK);
    LOAD = 1'b0; EN = 1'b1; UP = 1'b1;
    @(negedge CLK);
    #0.5 RST = 1'b1;
    #0.2;
    chk("async_bcd", 32'(BCD), 32'h0);
    chk("async_seg", SEG, S_RST);
    chk("async_tick", 32'(TICK), 32'h0);
    chk("async_ovf", 32'(OVF), 32'h0);
    @(negedge CLK);
    #0.3 RST = 1'b0;
    repeat (4) @(negedge CLK);
    chk("resume_bcd", 32'(BCD), 32'h0002);
    EN = 1'b0;

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
